ldl_shift_ring_arb: RTL
=======================

# ldl_shift_ring_arb

Round-robin arbiter and sequencer that shares one ring-rotation datapath between `NREQ` requesters. It accepts one rotation command at a time through per-requester valid/ready handshakes. It registers the operands, computes the rotation, and returns the result with the winner's ID on a single valid/ready response channel. It sits between several client blocks and the library's ring-shift function, serialising access so that only one rotator instance is built.

## Interface
Parameters:
- `WIDTH`, 8, data width in bits; must be ≥ 2; need not be a power of two.
- `NREQ`, 4, number of requesters; must be ≥ 2.
- Derived: `SW = $clog2(WIDTH)` (step width) and `IW = $clog2(NREQ)` (ID width).

Ports:
- `clk`, input, 1, single clock; all state changes on its rising edge.
- `rst`, input, 1, asynchronous, active-high reset.
- `req_valid`, input, `NREQ`, per-requester command valid.
- `req_ready`, output, `NREQ`, per-requester accept; at most one bit high.
- `req_dir`, input, `NREQ`, per-requester direction: 0 rotates right, 1 rotates left.
- `req_step`, input, `NREQ*SW`, per-requester rotate amount; requester i uses slice `[i*SW +: SW]`.
- `req_x`, input, `NREQ*WIDTH`, per-requester operand; requester i uses slice `[i*WIDTH +: WIDTH]`.
- `rsp_valid`, output, 1, result valid.
- `rsp_ready`, input, 1, consumer accepts the result.
- `rsp_id`, output, `IW`, index of the requester this result belongs to.
- `rsp_y`, output, `WIDTH`, rotated result.

## Operation
- FSM states: IDLE, CALC, RESP.
- **IDLE**
  - Grant is one-hot and combinational.
  - Priority starts at `(last_id+1) mod NREQ` and wraps upward.
  - `req_ready[g]=1` only for the granted requester g with `req_valid[g]=1`.
  - If no requester is valid, all `req_ready` bits are 0.
  - On a handshake: latch dir, step, x and the ID g into operand registers, set `last_id<=g`, and go to CALC.
- **CALC**
  - All `req_ready` bits are 0.
  - Compute `amt = step mod WIDTH`.
  - `rsp_y <=` x rotated right by `amt` (dir=0) or left by `amt` (dir=1).
  - `rsp_id <=` latched ID, `rsp_valid<=1`, go to RESP.
- **RESP**
  - All `req_ready` bits are 0.
  - `rsp_valid`, `rsp_id` and `rsp_y` hold stable until `rsp_valid & rsp_ready`.
  - On that handshake: `rsp_valid<=0`, go to IDLE.
- Arithmetic rules:
  - For dir=1, a left rotate by `amt` equals a right rotate by `(WIDTH-amt) mod WIDTH`. The subtraction is done at 32-bit width, then reduced.
  - step=0, or step a multiple of WIDTH, gives `rsp_y=x`.
- Requester rules:
  - A requester holds `req_valid` and its operands stable until `req_ready`.
  - The block never drops a valid request.
  - A request waits at most `NREQ-1` other grants (round-robin fairness).
- `req_valid` deasserting without a handshake is a protocol violation; behaviour is don't-care, and the bench asserts it never happens.
- Only one transaction is in flight. No new command is accepted in the cycle of the response handshake.

## Timing
- Reset values (asynchronous):
  - state = IDLE
  - `rsp_valid=0`, `rsp_id=0`, `rsp_y=0`
  - `last_id=NREQ-1`, so requester 0 has first priority
  - operand registers = 0
- Latency and throughput:
  - Accept on edge T, `rsp_valid` high after edge T+1.
  - With `rsp_ready=1`, the response completes on edge T+2 and the next accept is possible at edge T+3.
  - Peak throughput is 1 command per 3 cycles.
- `req_ready` depends combinationally on `req_valid` and state. `rsp_*` outputs are registered.
- Reset asserted in CALC or RESP:
  - The transaction is discarded and no response is produced.
  - The priority pointer returns to `NREQ-1`.
  - The requester must re-issue the command.
- Simultaneous `rsp_valid & rsp_ready` with new `req_valid`: the response completes and the request is accepted no earlier than the following cycle, in IDLE.

## Test plan
Use WIDTH=8, NREQ=4 unless noted.
1. **Reset:** assert `rst` mid-cycle with all `req_valid=1` → immediately `rsp_valid=0`, `rsp_y=0x00`, `rsp_id=0`, `req_ready=0000`. After release, the first grant goes to requester 0.
2. **Right rotate:** requester 0 only, dir=0, step=3, x=0x81 → `req_ready=0001` in the accept cycle; two edges later `rsp_valid=1`, `rsp_y=0x30`, `rsp_id=0`.
3. **Left rotate and step edge cases:**
   - requester 2, dir=1, step=1, x=0x80 → `rsp_y=0x01`, `rsp_id=2`
   - step=0, x=0xA5 → `rsp_y=0xA5`
   - WIDTH=6 build: dir=0, step=7, x=0b000001 → `rsp_y=0b100000`
4. **Fairness:** all four requesters valid continuously, `rsp_ready=1` → `rsp_id` sequence 0,1,2,3,0,1 with one response every 3 cycles. Then only requesters 1 and 3 valid → alternating 1,3,1,3.
5. **Backpressure:** `rsp_ready=0` for 5 cycles in RESP → `rsp_valid`, `rsp_y` and `rsp_id` stable and `req_ready=0000` throughout. Raising `rsp_ready` completes in 1 cycle.
6. **Reset mid-operation:** pulse `rst` while in CALC (requester 1 accepted) → no response appears. Requester 1 re-asserts and is served with the correct result.

Source files
------------

// File: rtl/ldl_shift_ring_arb.sv
// ldl_shift_ring_arb: round-robin arbiter in front of a single ring-rotation
// datapath. One command is accepted, rotated and returned at a time; the
// response carries the index of the requester that issued it.
module ldl_shift_ring_arb #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    localparam int SW = $clog2(WIDTH),
    localparam int IW = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_dir,
    input  logic [NREQ*SW-1:0]    req_step,
    input  logic [NREQ*WIDTH-1:0] req_x,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IW-1:0]         rsp_id,
    output logic [WIDTH-1:0]      rsp_y
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     last_id_q, last_id_d;
    logic              op_dir_q, op_dir_d;
    logic [SW-1:0]     op_step_q, op_step_d;
    logic [WIDTH-1:0]  op_x_q, op_x_d;
    logic [IW-1:0]     op_id_q, op_id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [IW-1:0]     rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]  rsp_y_q, rsp_y_d;

    logic              grant_found;
    logic [IW-1:0]     grant_idx;
    logic [31:0]       amt;
    logic [31:0]       rshift;
    logic [2*WIDTH-1:0] dbl_x;
    logic [WIDTH-1:0]  rot_y;

    // Per-requester views of the packed operand buses.
    logic [SW-1:0]     step_arr [NREQ];
    logic [WIDTH-1:0]  x_arr    [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign step_arr[gi] = req_step[gi*SW +: SW];
            assign x_arr[gi]    = req_x[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin search: first valid requester after the last winner, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!grant_found && req_valid[IW'((int'(last_id_q) + k) % NREQ)]) begin
                grant_found = 1'b1;
                grant_idx   = IW'((int'(last_id_q) + k) % NREQ);
            end
        end
    end

    // Ready is offered only in IDLE, to the winner alone, and never during reset.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grant_found && !rst) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Rotator: a left rotate is expressed as the complementary right rotate,
    // and the doubled operand lets a plain shift wrap for any WIDTH.
    always_comb begin
        amt    = 32'(op_step_q) % 32'(WIDTH);
        rshift = op_dir_q ? ((32'(WIDTH) - amt) % 32'(WIDTH)) : amt;
        dbl_x  = {op_x_q, op_x_q};
        rot_y  = WIDTH'(dbl_x >> rshift);
    end

    // Sequencer next-state: accept in IDLE, compute in CALC, hold in RESP.
    always_comb begin
        state_d     = state_q;
        last_id_d   = last_id_q;
        op_dir_d    = op_dir_q;
        op_step_d   = op_step_q;
        op_x_d      = op_x_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_y_d     = rsp_y_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    op_dir_d  = req_dir[grant_idx];
                    op_step_d = step_arr[grant_idx];
                    op_x_d    = x_arr[grant_idx];
                    op_id_d   = grant_idx;
                    last_id_d = grant_idx;
                    state_d   = CALC;
                end
            end
            CALC: begin
                rsp_y_d     = rot_y;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and operand registers; reset discards any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_id_q   <= IW'(NREQ - 1);
            op_dir_q    <= 1'b0;
            op_step_q   <= '0;
            op_x_q      <= '0;
            op_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_id_q   <= last_id_d;
            op_dir_q    <= op_dir_d;
            op_step_q   <= op_step_d;
            op_x_q      <= op_x_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_y_q     <= rsp_y_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;

endmodule
